// File: rtl/vga_timing_pkg.sv
// Shared VGA mode timing constants and the flag bundle carried down the
// video delay line.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  localparam axis_timing_t MODE_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t MODE_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam axis_timing_t MODE_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t MODE_800X600_V = '{active: 600, fp: 1,  sync: 4,  bp: 23};
  localparam axis_timing_t MODE_TEST_H    = '{active: 8,   fp: 2,  sync: 3,  bp: 2};
  localparam axis_timing_t MODE_TEST_V    = '{active: 4,   fp: 1,  sync: 2,  bp: 1};

  // hs/vs hold the final line levels, polarity already applied
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic line;
    logic frame;
  } vid_flags_t;

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of the timing generator: pixel request/return, sync
// outputs and the pixel-clock enable.
interface vga_timing_gen_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 10
);

  logic             ce;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] pixel_out;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic             pos_valid;
  logic             line_start;
  logic             frame_start;

  // master is the timing generator, slave is the pixel source / DAC side
  modport master (
    input  ce, pixel_in,
    output pixel_out, hsync, vsync, de, pos_x, pos_y, pos_valid,
           line_start, frame_start
  );

  modport slave (
    output ce, pixel_in,
    input  pixel_out, hsync, vsync, de, pos_x, pos_y, pos_valid,
           line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the raster: position counter plus
// active-area and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_active,
  output logic         o_sync,
  output logic         o_wrap
);

  localparam axis_timing_t TIMING     = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int unsigned  TOTAL      = axis_total(TIMING);
  localparam int unsigned  SYNC_START = ACTIVE + FP;
  localparam int unsigned  SYNC_END   = SYNC_START + SYNC;

  if (ACTIVE < 1 || SYNC < 1) begin : g_bad_timing
    $error("vga_axis_counter: active size and sync width must be at least 1");
  end

  logic [W-1:0] r_count;
  logic [31:0]  w_count32;
  logic         w_last;

  // widen before comparing so a window ending exactly at 2**W still decodes
  assign w_count32 = 32'(r_count);
  assign w_last    = (w_count32 == TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_active = (w_count32 < ACTIVE);
  assign o_sync   = ((w_count32 >= SYNC_START) && (w_count32 < SYNC_END)) ? POL : ~POL;
  assign o_wrap   = i_en && w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues pixel addresses, delays sync/de flags
// to match the pixel source latency and registers the DAC-side outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned      H_ACTIVE = MODE_640X480_H.active,
  parameter int unsigned      H_FP     = MODE_640X480_H.fp,
  parameter int unsigned      H_SYNC   = MODE_640X480_H.sync,
  parameter int unsigned      H_BP     = MODE_640X480_H.bp,
  parameter int unsigned      V_ACTIVE = MODE_640X480_V.active,
  parameter int unsigned      V_FP     = MODE_640X480_V.fp,
  parameter int unsigned      V_SYNC   = MODE_640X480_V.sync,
  parameter int unsigned      V_BP     = MODE_640X480_V.bp,
  parameter bit               HS_POL   = 1'b0,
  parameter bit               VS_POL   = 1'b0,
  parameter int unsigned      PIX_W    = 8,
  parameter int unsigned      LAT      = 1,
  parameter logic [PIX_W-1:0] BLANK    = '0
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);

  localparam vid_flags_t IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, line: 1'b0, frame: 1'b0};

  if (LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in 0..7");
  end

  logic [XW-1:0]    w_hcount;
  logic [YW-1:0]    w_vcount;
  logic             w_hactive;
  logic             w_vactive;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_hwrap;
  logic             w_vwrap;
  logic             r_top;
  vid_flags_t       w_head;
  vid_flags_t       w_tail;
  logic             r_de;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_line;
  logic             r_frame;
  logic [PIX_W-1:0] r_pixel;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (XW)
  ) u_hcount (
    .clk      (clk),
    .rst      (rst),
    .i_en     (bus.ce),
    .o_count  (w_hcount),
    .o_active (w_hactive),
    .o_sync   (w_hsync),
    .o_wrap   (w_hwrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (YW)
  ) u_vcount (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_hwrap),
    .o_count  (w_vcount),
    .o_active (w_vactive),
    .o_sync   (w_vsync),
    .o_wrap   (w_vwrap)
  );

  // set while the raster is on its first line, so frame start needs no cy compare
  always_ff @(posedge clk) begin
    if (rst || w_vwrap) begin
      r_top <= 1'b1;
    end else if (w_hwrap) begin
      r_top <= 1'b0;
    end
  end

  assign bus.pos_x     = w_hcount;
  assign bus.pos_y     = w_vcount;
  assign bus.pos_valid = w_hactive && w_vactive;

  assign w_head = '{
    de:    w_hactive && w_vactive,
    hs:    w_hsync,
    vs:    w_vsync,
    line:  (w_hcount == '0),
    frame: (w_hcount == '0) && r_top
  };

  if (LAT == 0) begin : g_nodelay
    assign w_tail = w_head;
  end else begin : g_delay
    vid_flags_t r_pipe [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(LAT); i++) begin
          r_pipe[i] <= IDLE;
        end
      end else if (bus.ce) begin
        r_pipe[0] <= w_head;
        for (int i = 1; i < int'(LAT); i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign w_tail = r_pipe[LAT-1];
  end

  // pulses drop on the first idle clk so they stay one clk wide under slow ce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de    <= 1'b0;
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      r_pixel <= BLANK;
    end else if (bus.ce) begin
      r_de    <= w_tail.de;
      r_hsync <= w_tail.hs;
      r_vsync <= w_tail.vs;
      r_line  <= w_tail.line;
      r_frame <= w_tail.frame;
      r_pixel <= w_tail.de ? bus.pixel_in : BLANK;
    end else begin
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end
  end

  assign bus.de          = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.line_start  = r_line;
  assign bus.frame_start = r_frame;
  assign bus.pixel_out   = r_pixel;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in the small test mode (H 8/2/3/2,
// V 4/1/2/1, LAT=2, BLANK=0xAA), with a second instance at inverted polarity.
module tb_vga_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.PIX_W(8), .X_W(4), .Y_W(3)) bus ();
  vga_timing_gen_if #(.PIX_W(8), .X_W(4), .Y_W(3)) busp ();

  assign bus.ce  = ce;
  assign busp.ce = ce;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(8), .LAT(2), .BLANK(8'hAA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_W(8), .LAT(2), .BLANK(8'hAA)
  ) dutp (
    .clk (clk),
    .rst (rst),
    .bus (busp)
  );

  // two-stage pixel sources returning x+16*y for each requested address
  logic [7:0] src1, src2, srcp1, srcp2;

  always_ff @(posedge clk) begin
    if (ce) begin
      src1  <= {1'b0, bus.pos_y, bus.pos_x};
      src2  <= src1;
      srcp1 <= {1'b0, busp.pos_y, busp.pos_x};
      srcp2 <= srcp1;
    end
  end

  assign bus.pixel_in  = src2;
  assign busp.pixel_in = srcp2;

  // expectations indexed by n = ce edges since reset release; outputs lag by 3
  function automatic int phase(int n);
    return (n >= 3) ? (n - 3) % FT : 0;
  endfunction

  function automatic bit exp_de(int n);
    int p = phase(n);
    return (n >= 3) && ((p % HT) < 8) && ((p / HT) < 4);
  endfunction

  function automatic bit exp_hs(int n);
    int p = phase(n);
    return (n >= 3) && ((p % HT) >= 10) && ((p % HT) < 13);
  endfunction

  function automatic bit exp_vs(int n);
    int p = phase(n);
    return (n >= 3) && ((p / HT) >= 5) && ((p / HT) < 7);
  endfunction

  function automatic bit exp_line(int n);
    return (n >= 3) && ((phase(n) % HT) == 0);
  endfunction

  function automatic bit exp_frame(int n);
    return (n >= 3) && (phase(n) == 0);
  endfunction

  function automatic logic [7:0] exp_pix(int n);
    int p = phase(n);
    return exp_de(n) ? 8'((p % HT) + 16 * (p / HT)) : 8'hAA;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    tick();
    checks++; if (bus.de !== 1'b0) $display("[TB] FAIL reset_de: got %0b, expected 0", bus.de); else passed++;
    checks++; if (bus.hsync !== 1'b1) $display("[TB] FAIL reset_hsync: got %0b, expected 1", bus.hsync); else passed++;
    checks++; if (bus.vsync !== 1'b1) $display("[TB] FAIL reset_vsync: got %0b, expected 1", bus.vsync); else passed++;
    checks++; if (bus.pixel_out !== 8'hAA) $display("[TB] FAIL reset_pixel: got %0h, expected aa", bus.pixel_out); else passed++;
    checks++; if (bus.line_start !== 1'b0) $display("[TB] FAIL reset_line: got %0b, expected 0", bus.line_start); else passed++;
    checks++; if (bus.frame_start !== 1'b0) $display("[TB] FAIL reset_frame: got %0b, expected 0", bus.frame_start); else passed++;
    checks++; if (bus.pos_x !== 4'd0 || bus.pos_y !== 3'd0) $display("[TB] FAIL reset_pos: got (%0d,%0d), expected (0,0)", bus.pos_x, bus.pos_y); else passed++;
    checks++; if (bus.pos_valid !== 1'b1) $display("[TB] FAIL reset_pos_valid: got %0b, expected 1", bus.pos_valid); else passed++;
    checks++; if (busp.hsync !== 1'b0 || busp.vsync !== 1'b0) $display("[TB] FAIL reset_pol_sync: got %0b%0b, expected 00", busp.hsync, busp.vsync); else passed++;
    rst = 1'b0;
  endtask

  typedef struct {
    int         c;
    bit         de;
    bit         hs;
    bit         ls;
    logic [7:0] pix;
  } hvec_t;

  task automatic test_horizontal();
    hvec_t hv [13] = '{
      '{1,  1'b0, 1'b1, 1'b0, 8'hAA},
      '{2,  1'b0, 1'b1, 1'b0, 8'hAA},
      '{3,  1'b1, 1'b1, 1'b1, 8'h00},
      '{4,  1'b1, 1'b1, 1'b0, 8'h01},
      '{10, 1'b1, 1'b1, 1'b0, 8'h07},
      '{11, 1'b0, 1'b1, 1'b0, 8'hAA},
      '{12, 1'b0, 1'b1, 1'b0, 8'hAA},
      '{13, 1'b0, 1'b0, 1'b0, 8'hAA},
      '{15, 1'b0, 1'b0, 1'b0, 8'hAA},
      '{16, 1'b0, 1'b1, 1'b0, 8'hAA},
      '{17, 1'b0, 1'b1, 1'b0, 8'hAA},
      '{18, 1'b1, 1'b1, 1'b1, 8'h10},
      '{33, 1'b1, 1'b1, 1'b1, 8'h20}
    };
    int vi = 0;
    do_reset();
    for (int c = 1; c <= 33; c++) begin
      tick();
      checks++;
      if (bus.pos_x !== 4'(c % HT) || bus.pos_y !== 3'((c / HT) % VT))
        $display("[TB] FAIL hpos@%0d: got (%0d,%0d), expected (%0d,%0d)", c, bus.pos_x, bus.pos_y, c % HT, (c / HT) % VT);
      else passed++;
      if (vi < 13 && hv[vi].c == c) begin
        checks++; if (bus.de !== hv[vi].de) $display("[TB] FAIL hde@%0d: got %0b, expected %0b", c, bus.de, hv[vi].de); else passed++;
        checks++; if (bus.hsync !== hv[vi].hs) $display("[TB] FAIL hsync@%0d: got %0b, expected %0b", c, bus.hsync, hv[vi].hs); else passed++;
        checks++; if (bus.line_start !== hv[vi].ls) $display("[TB] FAIL hline@%0d: got %0b, expected %0b", c, bus.line_start, hv[vi].ls); else passed++;
        checks++; if (bus.pixel_out !== hv[vi].pix) $display("[TB] FAIL hpix@%0d: got %0h, expected %0h", c, bus.pixel_out, hv[vi].pix); else passed++;
        vi++;
      end
    end
  endtask

  task automatic test_frame();
    do_reset();
    for (int n = 1; n <= 250; n++) begin
      tick();
      checks++; if (bus.frame_start !== exp_frame(n)) $display("[TB] FAIL frame@%0d: got %0b, expected %0b", n, bus.frame_start, exp_frame(n)); else passed++;
      checks++; if (bus.vsync !== !exp_vs(n)) $display("[TB] FAIL vsync@%0d: got %0b, expected %0b", n, bus.vsync, !exp_vs(n)); else passed++;
    end
  endtask

  task automatic test_pixel();
    do_reset();
    for (int n = 1; n <= 130; n++) begin
      tick();
      checks++; if (bus.de !== exp_de(n)) $display("[TB] FAIL pde@%0d: got %0b, expected %0b", n, bus.de, exp_de(n)); else passed++;
      checks++; if (bus.pixel_out !== exp_pix(n)) $display("[TB] FAIL pix@%0d: got %0h, expected %0h", n, bus.pixel_out, exp_pix(n)); else passed++;
    end
  endtask

  task automatic test_ce_gating();
    int n = 0;
    bit pulse;
    do_reset();
    for (int k = 0; k < 3 * 130; k++) begin
      ce = (k % 3 == 0);
      @(posedge clk);
      pulse = ce;
      if (ce) n++;
      @(negedge clk);
      checks++; if (bus.de !== exp_de(n)) $display("[TB] FAIL cde@%0d: got %0b, expected %0b", k, bus.de, exp_de(n)); else passed++;
      checks++; if (bus.hsync !== !exp_hs(n)) $display("[TB] FAIL chs@%0d: got %0b, expected %0b", k, bus.hsync, !exp_hs(n)); else passed++;
      checks++; if (bus.line_start !== (pulse && exp_line(n))) $display("[TB] FAIL cline@%0d: got %0b, expected %0b", k, bus.line_start, pulse && exp_line(n)); else passed++;
      checks++; if (bus.frame_start !== (pulse && exp_frame(n))) $display("[TB] FAIL cframe@%0d: got %0b, expected %0b", k, bus.frame_start, pulse && exp_frame(n)); else passed++;
      checks++; if (bus.pos_x !== 4'(n % HT)) $display("[TB] FAIL cposx@%0d: got %0d, expected %0d", k, bus.pos_x, n % HT); else passed++;
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midline();
    do_reset();
    for (int n = 1; n <= 35; n++) tick();
    checks++; if (bus.pos_x !== 4'd5 || bus.pos_y !== 3'd2) $display("[TB] FAIL mid_pos: got (%0d,%0d), expected (5,2)", bus.pos_x, bus.pos_y); else passed++;
    checks++; if (bus.de !== 1'b1) $display("[TB] FAIL mid_de: got %0b, expected 1", bus.de); else passed++;
    rst = 1'b1;
    tick();
    checks++; if (bus.de !== 1'b0 || bus.pixel_out !== 8'hAA) $display("[TB] FAIL mid_idle: got de=%0b pix=%0h, expected de=0 pix=aa", bus.de, bus.pixel_out); else passed++;
    checks++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) $display("[TB] FAIL mid_sync: got %0b%0b, expected 11", bus.hsync, bus.vsync); else passed++;
    checks++; if (bus.line_start !== 1'b0 || bus.frame_start !== 1'b0) $display("[TB] FAIL mid_pulse: got %0b%0b, expected 00", bus.line_start, bus.frame_start); else passed++;
    checks++; if (bus.pos_x !== 4'd0 || bus.pos_y !== 3'd0) $display("[TB] FAIL mid_pos0: got (%0d,%0d), expected (0,0)", bus.pos_x, bus.pos_y); else passed++;
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (bus.de !== (c == 3)) $display("[TB] FAIL rel_de@%0d: got %0b, expected %0b", c, bus.de, c == 3); else passed++;
      checks++; if (bus.pixel_out !== ((c == 3) ? 8'h00 : 8'hAA)) $display("[TB] FAIL rel_pix@%0d: got %0h", c, bus.pixel_out); else passed++;
    end
    checks++; if (bus.frame_start !== 1'b1 || bus.line_start !== 1'b1) $display("[TB] FAIL rel_pulse: got %0b%0b, expected 11", bus.frame_start, bus.line_start); else passed++;
  endtask

  task automatic test_polarity();
    do_reset();
    for (int n = 1; n <= 130; n++) begin
      tick();
      checks++; if (busp.hsync !== exp_hs(n)) $display("[TB] FAIL pol_hs@%0d: got %0b, expected %0b", n, busp.hsync, exp_hs(n)); else passed++;
      checks++; if (busp.vsync !== exp_vs(n)) $display("[TB] FAIL pol_vs@%0d: got %0b, expected %0b", n, busp.vsync, exp_vs(n)); else passed++;
      checks++; if (busp.de !== exp_de(n)) $display("[TB] FAIL pol_de@%0d: got %0b, expected %0b", n, busp.de, exp_de(n)); else passed++;
      checks++; if (busp.pixel_out !== exp_pix(n)) $display("[TB] FAIL pol_pix@%0d: got %0h, expected %0h", n, busp.pixel_out, exp_pix(n)); else passed++;
    end
  endtask

  initial begin
    $display("[TB] starting vga_timing_gen bench");
    test_reset();
    test_horizontal();
    test_frame();
    test_pixel();
    test_ce_gating();
    test_reset_midline();
    test_polarity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
